var_node_serial: RTL and testbench
==================================

# var_node_serial

Serial variable-node processor for the min-sum LDPC decoder. It sits directly downstream of the check-node min unit. It loads one channel LLR, accepts the DEG check-to-variable messages for one variable node one per handshake, and sums them into a total. It then returns DEG extrinsic variable-to-check messages (total minus own input), each saturated to the symmetric signed range, and emits a hard decision. All values are two's-complement fixed point, INT integer bits and FRAC fractional bits, the same format the check-node unit uses.

## Interface
- INT, 8, integer bits of message format
- FRAC, 8, fractional bits; W = INT+FRAC
- DEG, 3, variable-node degree (messages per node), ≥2

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a node; sampled only in IDLE
- llr_in  in  W  channel LLR, captured on accepted start
- in_valid  in  1  check message valid
- in_msg  in  W  check-to-variable message
- in_ready  out  1  high in COLLECT only
- out_valid  out  1  extrinsic message valid (EMIT only)
- out_msg  out  W  saturated extrinsic message
- out_ready  in  1  downstream accepts out_msg
- decision  out  1  hard decision, 1 = total negative
- decision_valid  out  1  one-cycle pulse when decision updates
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Reset is asynchronous and active-high. It forces state IDLE, index 0, and accumulator, message buffer and decision to 0. in_ready, out_valid, decision_valid, busy and out_msg are all 0.
- Accumulator width is A = W + clog2(DEG+1). Inputs are sign-extended to A, and all add/subtract is exact in A bits.
- Saturation: a result is clamped to [−(2^(W−1)−1), 2^(W−1)−1], i.e. 0x8001..0x7FFF for W=16. The value 0x8000 is never produced, so negation in the check-node unit cannot overflow.
- IDLE:
  - start=1 loads acc ← sext(llr_in) and idx ← 0, then moves to COLLECT.
  - in_valid is ignored.
- COLLECT:
  - in_ready=1.
  - Each cycle with in_valid&in_ready does buf[idx] ← in_msg, acc ← acc + sext(in_msg), idx++.
  - On the DEG-th accept: move to EMIT, idx ← 0, decision ← sign bit of the new acc, decision_valid=1 for the next cycle.
- EMIT:
  - out_valid=1 and out_msg = sat(acc − sext(buf[idx])). out_msg is a function of registers only.
  - On out_valid&out_ready, idx++. After the DEG-th transfer, move to IDLE.
- start outside IDLE is ignored. llr_in is not resampled.
- A total of exactly 0 gives decision=0.
- acc, buf and decision hold their values after returning to IDLE until the next start.

## Timing
- start accepted at cycle t gives in_ready=1 at t+1.
- At most one input per cycle. The DEG-th accept at cycle c gives out_valid=1 and decision_valid=1 at c+1.
- At most one output per cycle. The last transfer at cycle e gives busy=0 and in_ready=0 at e+1, and a new start is accepted at e+1.
- Minimum node time is 1 + DEG + DEG cycles (7 for DEG=3). There is no overlap between nodes.
- Backpressure: while out_ready=0, out_valid stays 1 and out_msg and idx are stable.
- Input stall: while in_valid=0, acc and idx hold.
- Reset asserted mid-node aborts immediately with no output. After deassertion the block waits for start.

## Test plan
- **Nominal** (DEG=3, Q8.8): llr_in=0x0100, in_msg=0x0080, 0xFF00, 0x0200 (total 0x0280) -> out_msg 0x0200, 0x0380, 0x0080 in order, decision=0, decision_valid pulses once, 7 cycles with no stalls.
- **Positive saturation**: llr_in=0x7000, in_msg=0x7000, 0x7000, 0x0000 -> out_msg 0x7FFF, 0x7FFF, 0x7FFF, decision=0.
- **Negative saturation**: llr_in=0x9000, in_msg=0x9000 ×3 -> out_msg 0x8001 ×3 (never 0x8000), decision=1.
- **Handshake stalls**: in_valid low 3 cycles between messages 1 and 2, then out_ready low 5 cycles during the second output -> results identical to the nominal case, out_msg stable while stalled, exactly 3 output transfers.
- **Reset mid-COLLECT**: assert rst after 2 accepted messages -> all outputs 0 asynchronously. Then run start with llr_in=0x0000, in_msg=0x0100 ×3 -> out_msg 0x0200 ×3, with no residue from the aborted node.
- **Ignored inputs**: in_valid pulses in IDLE, and start pulses during COLLECT and EMIT with llr_in=0x7FFF -> no state change, nominal-case results unaffected.

Source files
------------

// File: rtl/var_node_serial.sv
// Serial min-sum LDPC variable node: collects DEG check messages plus the channel LLR,
// then streams DEG saturated extrinsic messages (total minus own input) and a hard decision.
module var_node_serial #(
  parameter int INT  = 8,
  parameter int FRAC = 8,
  parameter int DEG  = 3,
  localparam int W   = INT + FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] llr_in,
  input  logic         in_valid,
  input  logic [W-1:0] in_msg,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_msg,
  input  logic         out_ready,
  output logic         decision,
  output logic         decision_valid,
  output logic         busy
);

  localparam int A  = W + $clog2(DEG + 1);
  localparam int IW = $clog2(DEG);
  localparam logic [IW-1:0] LAST = IW'(DEG - 1);
  localparam logic signed [A-1:0] SAT_MAX = {{(A-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [A-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [A-1:0]   acc_q, acc_d;
  logic [W-1:0]          buf_q [DEG];
  logic [W-1:0]          buf_d [DEG];
  logic                  decision_q, decision_d;
  logic                  dv_q, dv_d;
  logic signed [A-1:0]   diff;
  logic signed [A-1:0]   sat_val;

  function automatic logic signed [A-1:0] sext(input logic [W-1:0] v);
    return {{(A-W){v[W-1]}}, v};
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    buf_d      = buf_q;
    decision_d = decision_q;
    dv_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = sext(llr_in);
          idx_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          buf_d[idx_q] = in_msg;
          acc_d        = acc_q + sext(in_msg);
          if (idx_q == LAST) begin
            idx_d      = '0;
            state_d    = EMIT;
            decision_d = acc_d[A-1];
            dv_d       = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Extrinsic output is purely a function of registered state, so it is stable under backpressure.
  always_comb begin
    diff = acc_q - sext(buf_q[idx_q]);
    if (diff > SAT_MAX)      sat_val = SAT_MAX;
    else if (diff < SAT_MIN) sat_val = SAT_MIN;
    else                     sat_val = diff;
  end

  // NOTE: sequential state is updated only with non-blocking assignments to avoid simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      decision_q <= 1'b0;
      dv_q       <= 1'b0;
      // NOTE: the message buffer is small and must read as zero after reset, so it is reset explicitly.
      for (int i = 0; i < DEG; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      decision_q <= decision_d;
      dv_q       <= dv_d;
      for (int i = 0; i < DEG; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign in_ready       = (state_q == COLLECT);
  assign out_valid      = (state_q == EMIT);
  assign busy           = (state_q != IDLE);
  assign out_msg        = (state_q == EMIT) ? sat_val[W-1:0] : '0;
  assign decision       = decision_q;
  assign decision_valid = dv_q;

endmodule

// File: tb/tb_var_node_serial.sv
// Self-checking bench for var_node_serial: directed cases plus randomized nodes checked
// against a transaction-level arithmetic model of the extrinsic messages and decision.
module tb_var_node_serial;

  localparam int INT  = 8;
  localparam int FRAC = 8;
  localparam int DEG  = 3;
  localparam int W    = INT + FRAC;
  localparam int MAXV = 2**(W-1) - 1;

  typedef logic [W-1:0] word_t;
  typedef word_t vec_t [DEG];
  typedef int    gap_t [DEG];

  logic  clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  word_t llr_in = '0, in_msg = '0;
  logic  in_ready, out_valid, decision, decision_valid, busy;
  word_t out_msg;

  var_node_serial #(.INT(INT), .FRAC(FRAC), .DEG(DEG)) dut (
    .clk(clk), .rst(rst), .start(start), .llr_in(llr_in),
    .in_valid(in_valid), .in_msg(in_msg), .in_ready(in_ready),
    .out_valid(out_valid), .out_msg(out_msg), .out_ready(out_ready),
    .decision(decision), .decision_valid(decision_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int    n_chk = 0, n_pass = 0;
  int    dv_cnt = 0, busy_cnt = 0;
  word_t exp_q[$];
  logic  exp_dec_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: exact integer sums, then clamp to the symmetric range.
  function automatic int sx(input word_t v);
    return int'($signed(v));
  endfunction

  function automatic word_t sat(input int v);
    int c;
    c = (v > MAXV) ? MAXV : (v < -MAXV) ? -MAXV : v;
    return c[W-1:0];
  endfunction

  function automatic void model(input word_t llr, input vec_t m, output vec_t e, output logic dec);
    int total;
    total = sx(llr);
    foreach (m[i]) total += sx(m[i]);
    foreach (e[i]) e[i] = sat(total - sx(m[i]));
    dec = (total < 0);
  endfunction

  // Compare process: outputs are checked at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (in_ready || out_valid) check("busy_flag", busy, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) check("out_extra", out_valid, 0);
        else begin
          check("out_msg", out_msg, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (decision_valid) begin
        dv_cnt++;
        if (exp_dec_q.size() == 0) check("dv_extra", decision_valid, 0);
        else check("decision", decision, exp_dec_q.pop_front());
      end
    end
  end

  task automatic do_start(input word_t llr);
    start  = 1'b1;
    llr_in = llr;
    @(posedge clk); #1;
    start  = 1'b0;
    llr_in = word_t'($urandom);
  endtask

  task automatic send_msg(input word_t m, input int gap, input bit noise);
    bit seen;
    int guard;
    guard    = 0;
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (gap) begin
      in_msg = word_t'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_msg   = m;
    if (noise) begin
      start  = 1'b1;
      llr_in = 16'h7FFF;
    end
    do begin
      seen = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!seen && guard < 100);
    in_valid = 1'b0;
    start    = 1'b0;
    check("msg_accepted", seen, 1);
  endtask

  // mode 0: always ready, 1: random ready, 2: five-cycle stall on the second output.
  task automatic drain(input int mode, input bit noise);
    int xfers, stalls, guard;
    xfers = 0; stalls = 0; guard = 0;
    while (busy && guard < 500) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (xfers == 1 && stalls < 5) begin
            out_ready = 1'b0;
            stalls++;
          end else out_ready = 1'b1;
        end
      endcase
      start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      llr_in = 16'h7FFF;
      if (out_valid && out_ready) xfers++;
      @(posedge clk); #1;
      guard++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("node_done", busy, 0);
    check("transfers", xfers, DEG);
  endtask

  task automatic run_node(input word_t llr, input vec_t m, input gap_t g,
                          input int mode, input bit noise, input bit time_chk);
    vec_t e;
    logic d;
    model(llr, m, e, d);
    foreach (e[i]) exp_q.push_back(e[i]);
    exp_dec_q.push_back(d);
    dv_cnt   = 0;
    busy_cnt = 0;
    do_start(llr);
    check("in_ready_after_start", in_ready, 1);
    for (int i = 0; i < DEG; i++) send_msg(m[i], g[i], noise);
    check("out_valid_after_last", out_valid, 1);
    check("dv_after_last", decision_valid, 1);
    drain(mode, noise);
    check("dv_pulses", dv_cnt, 1);
    check("outputs_left", exp_q.size(), 0);
    if (time_chk) check("node_cycles", busy_cnt + 1, 1 + 2 * DEG);
  endtask

  task automatic idle_noise();
    repeat (3) begin
      in_valid = 1'b1;
      in_msg   = word_t'($urandom);
      @(posedge clk); #1;
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t m, e;
    gap_t g0, gs;
    logic d;
    g0 = '{0, 0, 0};
    gs = '{0, 3, 0};

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_msg", out_msg, 0);
    check("rst_decision", decision, 0);
    check("rst_dv", decision_valid, 0);
    check("rst_busy", busy, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed pins for the model
    m = '{16'h0080, 16'hFF00, 16'h0200};
    model(16'h0100, m, e, d);
    check("pin_nom_e0", e[0], 16'h0200);
    check("pin_nom_e1", e[1], 16'h0380);
    check("pin_nom_e2", e[2], 16'h0080);
    check("pin_nom_dec", d, 0);
    m = '{16'h7000, 16'h7000, 16'h0000};
    model(16'h7000, m, e, d);
    check("pin_pos_e2", e[2], 16'h7FFF);
    m = '{16'h9000, 16'h9000, 16'h9000};
    model(16'h9000, m, e, d);
    check("pin_neg_e0", e[0], 16'h8001);
    check("pin_neg_dec", d, 1);

    // Nominal, no stalls, exact node time
    m = '{16'h0080, 16'hFF00, 16'h0200};
    run_node(16'h0100, m, g0, 0, 1'b0, 1'b1);
    check("nom_decision_hold", decision, 0);

    // Positive saturation
    m = '{16'h7000, 16'h7000, 16'h0000};
    run_node(16'h7000, m, g0, 0, 1'b0, 1'b0);
    check("pos_decision", decision, 0);

    // Negative saturation
    m = '{16'h9000, 16'h9000, 16'h9000};
    run_node(16'h9000, m, g0, 0, 1'b0, 1'b0);
    check("neg_decision_hold", decision, 1);

    // Reset mid-COLLECT after two accepted messages
    do_start(16'h0100);
    send_msg(16'h7000, 0, 1'b0);
    send_msg(16'h7000, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_msg", out_msg, 0);
    check("abort_decision", decision, 0);
    check("abort_dv", decision_valid, 0);
    check("abort_busy", busy, 0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    check("post_abort_idle", busy, 0);
    m = '{16'h0100, 16'h0100, 16'h0100};
    run_node(16'h0000, m, g0, 0, 1'b0, 1'b0);

    // Handshake stalls on both sides
    m = '{16'h0080, 16'hFF00, 16'h0200};
    run_node(16'h0100, m, gs, 2, 1'b0, 1'b0);

    // Ignored inputs: in_valid in IDLE, start during COLLECT and EMIT
    idle_noise();
    run_node(16'h0100, m, g0, 0, 1'b1, 1'b0);

    // Exact zero total gives decision 0
    m = '{16'hFF00, 16'h0000, 16'h0000};
    run_node(16'h0100, m, g0, 0, 1'b0, 1'b0);
    check("zero_total_decision", decision, 0);

    // Randomized nodes
    for (int n = 0; n < 40; n++) begin
      vec_t rm;
      gap_t rg;
      word_t rl;
      rl = word_t'($urandom);
      foreach (rm[i]) begin
        rm[i] = word_t'($urandom);
        rg[i] = $urandom_range(0, 2);
      end
      run_node(rl, rm, rg, 1, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) idle_noise();
    end

    check("decisions_left", exp_dec_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
